// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with starvation watchdogs.
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  // Widest request vector the picker handles; callers zero-extend narrower ones.
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned PICK_W  = 4;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // Width of a channel index; never less than one bit.
  function automatic int unsigned idw_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set request at or after ptr, scanning upward and wrapping at n-1 -> 0.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [PICK_W-1:0]  ptr,
                                       input int unsigned        n);
    rr_pick_t    pick;
    int unsigned c;
    pick = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      c = (32'(ptr) + k) % n;
      if ((k < n) && !pick.found && req[c[PICK_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = c[PICK_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_wait_wdog.sv
// Single-channel starvation watchdog: saturating request-without-grant counter
// with a flag that stays set until reset once the limit is reached.
module rr_wait_wdog
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starve
);

  localparam int unsigned     WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_LIM = WW'(MAX_WAIT);

  logic [WW-1:0] cnt;
  logic [WW-1:0] cnt_nxt;

  // Count cycles spent requesting without a grant, holding at the limit.
  always_comb begin
    cnt_nxt = cnt;
    if (!req || gnt) begin
      cnt_nxt = '0;
    end else if (cnt != WAIT_LIM) begin
      cnt_nxt = cnt + WW'(1);
    end
  end

  // Counter register and sticky starvation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      starve <= starve | (cnt_nxt == WAIT_LIM);
    end
  end

endmodule

// File: rtl/rr_arb_wdog.sv
// N-requester round-robin arbiter with hold/release handshake, forced release
// after HOLD_MAX cycles and per-channel starvation watchdogs.
// Optional: define RR_ARB_WDOG_SVA_EN to compile embedded concurrent assertions.
module rr_arb_wdog
  import rr_arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned HOLD_MAX = 8,
  parameter  int unsigned MAX_WAIT = 32,
  localparam int unsigned IDW      = idw_of(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [IDW-1:0]   gnt_id,
  output logic [N_REQ-1:0] starve,
  output logic             force_rel,
  output logic             err_done
);

  localparam int unsigned   HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  arb_state_e       state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt, gnt_id_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             force_nxt;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t         pick;
  logic             rel_done, rel_drop, rel_hold;

  // Widen the request vector to the picker's fixed width.
  always_comb begin
    req_ext = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ext[i] = req[i];
    end
  end

  assign pick    = rr_pick(req_ext, PICK_W'(ptr), N_REQ);
  assign gnt_vld = |gnt;

  // Next-state and registered-output decode; a release always passes through
  // IDLE, which is what creates the one-cycle bubble between grants.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    ptr_nxt    = ptr;
    hold_nxt   = hold_cnt;
    force_nxt  = 1'b0;
    rel_done   = done[gnt_id];
    rel_drop   = !req[gnt_id];
    rel_hold   = (hold_cnt == HOLD_LIM);
    unique case (state)
      IDLE: begin
        if (pick.found) begin
          state_nxt                    = GRANT;
          gnt_nxt                      = '0;
          gnt_nxt[pick.idx[IDW-1:0]]   = 1'b1;
          gnt_id_nxt                   = pick.idx[IDW-1:0];
          hold_nxt                     = HW'(1);
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
          ptr_nxt    = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
          hold_nxt   = '0;
          force_nxt  = rel_hold && !rel_done && !rel_drop;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
  end

  // Arbiter state, grant outputs and sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      force_rel <= 1'b0;
      err_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      force_rel <= force_nxt;
      err_done  <= err_done | (|(done & ~gnt));
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_wdog
    rr_wait_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req[i]),
      .gnt    (gnt[i]),
      .starve (starve[i])
    );
  end

`ifdef RR_ARB_WDOG_SVA_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("%m: more than one grant asserted");
  a_vld: assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == |gnt)
    else $error("%m: gnt_vld inconsistent with gnt");
  a_force: assert property (@(posedge clk) disable iff (!rst_n) force_rel |-> $past(gnt_vld))
    else $error("%m: force_rel without a preceding grant");
  a_idle: assert property (@(posedge clk) disable iff (!rst_n)
                           (state == IDLE && req != '0) |=> gnt_vld)
    else $error("%m: pending request not granted from IDLE");
  for (genvar i = 0; i < N_REQ; i++) begin : g_sva
    a_wait: assert property (@(posedge clk) disable iff (!rst_n)
                             req[i] |-> ##[0:MAX_WAIT-1] gnt[i])
      else $error("%m: request-to-grant latency bound exceeded");
  end
`endif

endmodule

// File: tb/tb_rr_arb_wdog.sv
// Scoreboard bench for rr_arb_wdog: a cycle-level reference model pushes the
// expected outputs after every clock edge; a monitor pops and compares them.
module tb_rr_arb_wdog;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int HOLD = 4;
  localparam int MAXW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   starve;
  logic           force_rel;
  logic           err_done;

  always #5 clk = ~clk;

  rr_arb_wdog #(.N_REQ(N), .HOLD_MAX(HOLD), .MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .starve    (starve),
    .force_rel (force_rel),
    .err_done  (err_done)
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic [N-1:0]   starve;
    logic           frc;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: granted channel (-1 = none), cycles held, next start.
  int           m_gid = -1;
  int           m_hold = 0;
  int           m_ptr = 0;
  int           m_wait[N];
  logic [N-1:0] m_starve = '0;
  logic         m_err = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: evaluates the arbitration rules once per clock edge.
  always @(posedge clk) begin
    exp_t e;
    logic frc;
    int   c;
    frc = 1'b0;
    if (!rst_n) begin
      m_gid = -1; m_hold = 0; m_ptr = 0; m_starve = '0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_gid != i) begin
          if (m_wait[i] < MAXW) m_wait[i]++;
          if (m_wait[i] == MAXW) m_starve[i] = 1'b1;
        end else begin
          m_wait[i] = 0;
        end
        if (done[i] && m_gid != i) m_err = 1'b1;
      end
      if (m_gid < 0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_gid = c; m_hold = 1;
            break;
          end
        end
      end else if (done[m_gid] || !req[m_gid] || m_hold == HOLD) begin
        frc    = !done[m_gid] && req[m_gid];
        m_ptr  = (m_gid + 1) % N;
        m_gid  = -1;
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end
    e.gnt    = (m_gid < 0) ? '0 : N'(1) << m_gid;
    e.id     = (m_gid < 0) ? '0 : IDW'(m_gid);
    e.starve = m_starve;
    e.frc    = frc;
    e.err    = m_err;
    sb.push_back(e);
  end

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst_n) e = '0;
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("gnt_vld", 32'(gnt_vld), 32'(|e.gnt));
      chk("gnt_id", 32'(gnt_id), 32'(e.id));
      chk("starve", 32'(starve), 32'(e.starve));
      chk("force_rel", 32'(force_rel), 32'(e.frc));
      chk("err_done", 32'(err_done), 32'(e.err));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    @(posedge clk); #1;
    req  = r;
    done = d;
  endtask

  task automatic rand_cycle(input bit spur);
    logic [N-1:0] r, d;
    @(posedge clk); #1;
    r = req;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (m_gid == i) begin
        case ($urandom_range(7))
          0:       d[i] = 1'b1;
          1:       begin d[i] = 1'b1; r[i] = 1'b0; end
          2:       r[i] = 1'b0;
          default: ;
        endcase
      end else if (r[i]) begin
        if ($urandom_range(23) == 0) r[i] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        r[i] = 1'b1;
      end
    end
    if (spur && $urandom_range(15) == 0) d[$urandom_range(N-1)] = 1'b1;
    req  = r;
    done = d;
  endtask

  initial begin
    logic [N-1:0] d;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_vld", 32'(gnt_vld), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_starve", 32'(starve), 0);
    chk("rst_force_rel", 32'(force_rel), 0);
    chk("rst_err_done", 32'(err_done), 0);
    rst_n = 1'b1;

    // Single request, released by done
    repeat (3) step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    repeat (3) step(4'b0000, 4'b0000);

    // Full contention, done two cycles into each grant
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      d = '0;
      if (m_gid >= 0 && m_hold == 2) d[m_gid] = 1'b1;
      req  = 4'b1111;
      done = d;
    end
    repeat (3) step(4'b0000, 4'b0000);

    // Forced release by hold limit
    repeat (20) step(4'b0010, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Spurious done while granted and while idle
    repeat (3) step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0010);
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0010);
    repeat (2) step(4'b0000, 4'b0000);

    // Reset in the middle of a grant
    step(4'b1000, 4'b0000);
    for (int n = 0; n < 10 && m_gid != 3; n++) step(4'b1000, 4'b0000);
    @(posedge clk); #1;
    chk("pre_rst_gnt", 32'(gnt), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 0);
    chk("async_rst_gnt_vld", 32'(gnt_vld), 0);
    req = 4'b1001;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(4'b1001, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Random traffic with well-formed done pulses
    repeat (1500) rand_cycle(1'b0);

    // Clean restart, then random traffic including stray done pulses
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; done = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (500) rand_cycle(1'b1);

    step(4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_wdog.md
Name: rr_arb_wdog

Overview:
- Parametrised N-requester round-robin arbiter. It generalises the two-requester mutually-exclusive-grant arbiter to N_REQ channels.
- Adds grant hold/release handshake, forced release after HOLD_MAX cycles, and per-channel starvation watchdogs.
- Sits between bus masters and a shared resource. Guarantees at most one grant and bounded request-to-grant latency.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- HOLD_MAX, 8, max consecutive cycles one grant may be held before forced release
- MAX_WAIT, 32, req-without-gnt cycles before the channel's starve flag sets; must exceed (N_REQ-1)*(HOLD_MAX+1)+1

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-channel request, level, held until granted
- done  in  N_REQ  per-channel release pulse, valid only while that channel is granted
- gnt  out  N_REQ  registered grant, one-hot or zero
- gnt_vld  out  1  OR of gnt
- gnt_id  out  IDW=$clog2(N_REQ)  index of granted channel, 0 when gnt_vld=0
- starve  out  N_REQ  sticky per-channel starvation flag
- force_rel  out  1  one-cycle pulse when HOLD_MAX expiry forces a release
- err_done  out  1  sticky; done seen on a channel not currently granted

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_vld=0, gnt_id=0, starve=0, force_rel=0, err_done=0. FSM=IDLE, rr pointer=0, hold counter=0, wait counters=0. Deassertion is synchronised externally; the block only requires async assert.
- FSM states: IDLE, GRANT.
- IDLE, when req != 0:
  - Select the first set req at or after pointer, scanning upward with wrap N_REQ-1 -> 0.
  - Next edge: gnt[sel]=1, gnt_id=sel, state=GRANT, hold counter=1.
  - Latency: req sampled high at edge k with no contention gives gnt visible after edge k+1 (req |=> gnt).
- IDLE, when req == 0: stay in IDLE, outputs 0.
- GRANT, per edge:
  - Release if done[gnt_id]=1 or req[gnt_id]=0 or hold counter==HOLD_MAX.
  - On release: gnt=0, state=IDLE, pointer=(gnt_id+1) mod N_REQ, hold counter=0.
  - If release is due to HOLD_MAX only (no done, req still high), force_rel pulses on the same edge.
  - Otherwise hold counter increments.
- One idle bubble cycle always separates consecutive grants. No back-to-back grants.
- Simultaneous done and HOLD_MAX expiry: normal release, no force_rel.
- done on a non-granted channel, or in IDLE: ignored for arbitration; err_done sets.
- Wait counter per channel, width $clog2(MAX_WAIT+1):
  - Increments each cycle req[i]=1 and gnt[i]=0.
  - Clears when req[i]=0 or gnt[i]=1.
  - Saturates at MAX_WAIT. Reaching MAX_WAIT sets starve[i], which stays set until reset.
- Request dropped while waiting: wait counter clears and no grant is issued for that channel.
- Reset mid-grant: gnt drops immediately (async), pointer returns to 0.
- Invariant: $onehot0(gnt) in every cycle.

Optional Feature:
- Macro: RR_ARB_WDOG_SVA_EN.
- When defined, the module embeds concurrent assertions, all clocked @(posedge clk) disable iff (!rst_n):
  - $onehot0(gnt)
  - gnt_vld == |gnt
  - req[i] |-> ##[0:MAX_WAIT-1] gnt[i]
  - force_rel |-> $past(gnt_vld)
  - (state==IDLE && req!=0) |=> gnt_vld
  - Each assertion has an else $error("%m ...") message.
- When undefined, no assertion code is compiled. RTL behaviour is identical either way.

Decomposition:
- Package rr_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_e
  - function rr_pick(req, ptr) returning index and found bit
  - localparam helper for IDW
- One natural sub-module: rr_wait_wdog, a single-channel saturating wait counter plus sticky flag. It is instantiated N_REQ times in a generate loop.

Test Plan:
- Single req: req=4'b0100 held from cycle 2 -> gnt=4'b0100, gnt_id=2 from cycle 3; done[2] at cycle 5 -> gnt=0 at cycle 6, pointer=3.
- Contention fairness: req=4'b1111 held, done pulsed 2 cycles into each grant -> grant order 0,1,2,3,0 with one idle cycle between grants; never two bits of gnt set.
- Forced release: HOLD_MAX=8, req[1] held, no done -> gnt[1] high 8 cycles, force_rel pulse on the release edge, IDLE one cycle, then gnt[1] again if no other req.
- Starvation: MAX_WAIT=4, HOLD_MAX=8, req[0] held with no done, req[3] held -> starve[3]=1 after 4 wait cycles and stays 1 after the grant.
- Spurious done: done=4'b0010 while gnt=4'b0001 -> err_done=1, gnt unchanged; same pulse while IDLE -> err_done stays 1.
- Mid-grant reset: rst_n=0 while gnt=4'b1000 -> gnt=0 asynchronously; after release with req=4'b1001, first grant goes to channel 0.
